interrupt_ack_sequencer: RTL and testbench
==========================================

Name: interrupt_ack_sequencer

Overview:
- Sequences the CPU interrupt-acknowledge handshake for the 8259A.
- Raises INT from the priority resolver's highest pending request and counts INTA pulses (2 in 8086 mode, 3 in MCS-80 mode).
- Captures the acknowledged level, drives the vector/CALL bytes onto the data bus, and produces the acknowledge_interrupt and end_of_acknowledge_sequence strobes that the ISR and OCW2/EOI logic consume.

Parameters:
ACK_TIMEOUT, 255, max clock cycles allowed in any gap between INTA pulses before the sequence is aborted; counter width is clog2(ACK_TIMEOUT+1).

Ports:
clock  input  1  system clock; all state changes on rising edge
reset_n  input  1  synchronous, active-low reset
write_initial_command_word_1  input  1  ICW1 write strobe; aborts any sequence
u8086_or_mcs80_config  input  1  1 = 8086 mode, 0 = MCS-80/85 mode
call_address_interval_4_or_8_config  input  1  1 = interval 4, 0 = interval 8 (MCS-80 only)
vector_address_low  input  3  A7..A5 from ICW1
vector_address_high  input  8  ICW2 byte; [7:3] = T7..T3 in 8086 mode
interrupt  input  8  one-hot highest-priority unmasked request; 0 = none
interrupt_acknowledge_n  input  1  INTA#, already synchronous to clock
interrupt_to_cpu  output  1  INT pin
acknowledge_interrupt  output  8  one-cycle one-hot pulse; sets the ISR bit
end_of_acknowledge_sequence  output  1  one-cycle pulse at end of the last INTA pulse
out_control_logic_data  output  1  data-bus drive enable
control_logic_data  output  8  byte driven onto the data bus

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE, all outputs 0, level=0, timeout counter=0, INTA history register=1.
- Edge detection:
  - inta_prev is the registered interrupt_acknowledge_n.
  - fall = inta_prev & ~interrupt_acknowledge_n.
  - rise = ~inta_prev & interrupt_acknowledge_n.
- All outputs are registered and respond one cycle after the edge on which fall/rise is seen.
- States: IDLE, P1, G1, P2, G2, P3. Pn = INTA pulse n low; Gn = gap after pulse n.
- IDLE:
  - interrupt_to_cpu = (interrupt != 0), registered.
  - On fall: latch level = bit2num(interrupt), or 7 if interrupt==0 (spurious). Pulse acknowledge_interrupt = interrupt (all-zero if spurious). Clear interrupt_to_cpu. Go to P1.
- P1:
  - MCS-80: drive 0xCD.
  - 8086: no drive.
  - On rise: go to G1.
- G1: on fall, go to P2.
- P2:
  - 8086: drive {vector_address_high[7:3], level}.
  - MCS-80 interval 4: drive {vector_address_low[2:0], level, 2'b00}.
  - MCS-80 interval 8: drive {vector_address_low[2:1], level, 3'b000}.
  - On rise: 8086 pulses end_of_acknowledge_sequence and goes to IDLE; MCS-80 goes to G2.
- G2: on fall, go to P3.
- P3:
  - Drive vector_address_high.
  - On rise: pulse end_of_acknowledge_sequence and go to IDLE.
- Drive timing:
  - out_control_logic_data=1 and control_logic_data valid only while in a driving P state.
  - Both go to 0 the cycle after rise.
  - control_logic_data=0 whenever not driving.
- Timeout:
  - The counter clears on every fall/rise and increments each cycle in G1/G2.
  - Reaching ACK_TIMEOUT returns to IDLE with no end_of_acknowledge_sequence pulse. The ISR bit already set remains for software EOI.
- interrupt_to_cpu is held 0 from the first fall until IDLE is re-entered. It may reassert the cycle after returning to IDLE.
- Mode and config inputs are sampled live; software must not change them mid-sequence.
- A write_initial_command_word_1 pulse in any state:
  - forces IDLE, clears all outputs and the counter, and suppresses the end pulse;
  - takes priority over a simultaneous fall or rise.
- Reset asserted mid-sequence behaves identically to the write_initial_command_word_1 abort.
- Changes on interrupt after the first fall are ignored; the level is frozen until IDLE.

Test Plan:
1. 8086, vector_address_high=0x40, interrupt=0x08, two INTA pulses -> INT=1, then acknowledge_interrupt=0x08 for 1 cycle after fall 1, no drive in P1, drive 0x43 in P2, end_of_acknowledge_sequence 1 cycle after rise 2, INT low throughout.
2. MCS-80, vector_address_low=3'b101, vector_address_high=0x12, interval 4, interrupt=0x20 -> bytes 0xCD, 0xB4, 0x12 across three pulses; end pulse after rise 3.
3. Same as 2 with interval 8 -> second byte 0xA8.
4. Spurious: interrupt drops to 0 before fall 1 in 8086 mode with vector_address_high=0x40 -> acknowledge_interrupt=0x00, vector 0x47, end pulse still issued.
5. Timeout: ACK_TIMEOUT=8, stall in G1 for 8 cycles -> IDLE, no end pulse; a fresh request reasserts INT next cycle.
6. Abort: write_initial_command_word_1 coincident with rise 2 in 8086 mode -> IDLE, drive 0, no end pulse. Repeat with reset_n=0 in P2 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/interrupt_ack_sequencer_if.sv
// CPU-side interrupt handshake bundle for the 8259A acknowledge sequencer:
// resolved request in, INTA# in, INT pin, ISR set pulse, end strobe and data bus out.
interface interrupt_ack_sequencer_if;
  logic [7:0] interrupt;
  logic       interrupt_acknowledge_n;
  logic       interrupt_to_cpu;
  logic [7:0] acknowledge_interrupt;
  logic       end_of_acknowledge_sequence;
  logic       out_control_logic_data;
  logic [7:0] control_logic_data;

  // Sequencer side.
  modport master (
    input  interrupt,
    input  interrupt_acknowledge_n,
    output interrupt_to_cpu,
    output acknowledge_interrupt,
    output end_of_acknowledge_sequence,
    output out_control_logic_data,
    output control_logic_data
  );

  // Priority resolver / CPU side.
  modport slave (
    output interrupt,
    output interrupt_acknowledge_n,
    input  interrupt_to_cpu,
    input  acknowledge_interrupt,
    input  end_of_acknowledge_sequence,
    input  out_control_logic_data,
    input  control_logic_data
  );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// 8259A interrupt-acknowledge sequencer: raises INT, counts INTA# pulses (2 for 8086,
// 3 for MCS-80/85), sets the ISR bit and drives CALL/vector bytes onto the data bus.
module interrupt_ack_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       write_initial_command_word_1,
  input  logic       u8086_or_mcs80_config,
  input  logic       call_address_interval_4_or_8_config,
  input  logic [2:0] vector_address_low,
  input  logic [7:0] vector_address_high,
  interrupt_ack_sequencer_if.master ack_if
);

  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StP1, StG1, StP2, StG2, StP3} state_e;

  state_e          state_q, state_d;
  logic [2:0]      level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            inta_prev_q;
  logic            int_q, int_d;
  logic [7:0]      ack_q, ack_d;
  logic            eoa_q, eoa_d;
  logic            oe_q, oe_d;
  logic [7:0]      data_q, data_d;
  logic            fall, rise;

  // An all-zero request falls through to 7, the spurious level.
  function automatic logic [2:0] bit2num(input logic [7:0] onehot);
    logic [2:0] num;
    num = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (onehot[i]) num = 3'(i);
    end
    return num;
  endfunction

  always_comb begin
    fall    = inta_prev_q & ~ack_if.interrupt_acknowledge_n;
    rise    = ~inta_prev_q & ack_if.interrupt_acknowledge_n;
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    ack_d   = 8'h00;
    eoa_d   = 1'b0;
    oe_d    = 1'b0;
    data_d  = 8'h00;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (fall) begin
          level_d = bit2num(ack_if.interrupt);
          ack_d   = ack_if.interrupt;
          state_d = StP1;
        end
      end
      StP1: begin
        if (rise) begin
          cnt_d   = '0;
          state_d = StG1;
        end
      end
      StG1: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = StP2;
        end else if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StP2: begin
        if (rise) begin
          cnt_d = '0;
          if (u8086_or_mcs80_config) begin
            eoa_d   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StG2;
          end
        end
      end
      StG2: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = StP3;
        end else if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StP3: begin
        if (rise) begin
          cnt_d   = '0;
          eoa_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Bus drive follows the state being entered so it appears one cycle after the edge.
    case (state_d)
      StP1: begin
        if (!u8086_or_mcs80_config) begin
          oe_d   = 1'b1;
          data_d = 8'hCD;
        end
      end
      StP2: begin
        oe_d = 1'b1;
        if (u8086_or_mcs80_config) begin
          data_d = {vector_address_high[7:3], level_d};
        end else if (call_address_interval_4_or_8_config) begin
          data_d = {vector_address_low[2:0], level_d, 2'b00};
        end else begin
          data_d = {vector_address_low[2:1], level_d, 3'b000};
        end
      end
      StP3: begin
        oe_d   = 1'b1;
        data_d = vector_address_high;
      end
      default: ;
    endcase

    int_d = (state_d == StIdle) && (ack_if.interrupt != 8'h00);

    if (write_initial_command_word_1) begin
      state_d = StIdle;
      level_d = level_q;
      cnt_d   = '0;
      int_d   = 1'b0;
      ack_d   = 8'h00;
      eoa_d   = 1'b0;
      oe_d    = 1'b0;
      data_d  = 8'h00;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      level_q     <= 3'd0;
      cnt_q       <= '0;
      inta_prev_q <= 1'b1;
      int_q       <= 1'b0;
      ack_q       <= 8'h00;
      eoa_q       <= 1'b0;
      oe_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      inta_prev_q <= ack_if.interrupt_acknowledge_n;
      int_q       <= int_d;
      ack_q       <= ack_d;
      eoa_q       <= eoa_d;
      oe_q        <= oe_d;
      data_q      <= data_d;
    end
  end

  assign ack_if.interrupt_to_cpu            = int_q;
  assign ack_if.acknowledge_interrupt       = ack_q;
  assign ack_if.end_of_acknowledge_sequence = eoa_q;
  assign ack_if.out_control_logic_data      = oe_q;
  assign ack_if.control_logic_data          = data_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer: 8086 and MCS-80 sequences, spurious
// request, gap timeout and ICW1/reset aborts, all against hand-computed values.
module tb_interrupt_ack_sequencer;
  logic       clock = 1'b0;
  logic       reset_n;
  logic       icw1;
  logic       mode_8086;
  logic       interval_4;
  logic [2:0] val;
  logic [7:0] vah;
  int         n_checks = 0;
  int         n_errors = 0;

  interrupt_ack_sequencer_if ack_if ();

  interrupt_ack_sequencer #(
    .ACK_TIMEOUT(8)
  ) u_dut (
    .clock                               (clock),
    .reset_n                             (reset_n),
    .write_initial_command_word_1        (icw1),
    .u8086_or_mcs80_config               (mode_8086),
    .call_address_interval_4_or_8_config (interval_4),
    .vector_address_low                  (val),
    .vector_address_high                 (vah),
    .ack_if                              (ack_if)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic i, input logic [7:0] a,
                           input logic e, input logic oe, input logic [7:0] d);
    check({tag, ".int"}, 32'(ack_if.interrupt_to_cpu), 32'(i));
    check({tag, ".ack"}, 32'(ack_if.acknowledge_interrupt), 32'(a));
    check({tag, ".eoa"}, 32'(ack_if.end_of_acknowledge_sequence), 32'(e));
    check({tag, ".oe"}, 32'(ack_if.out_control_logic_data), 32'(oe));
    check({tag, ".data"}, 32'(ack_if.control_logic_data), 32'(d));
  endtask

  task automatic inta(input logic v);
    ack_if.interrupt_acknowledge_n = v;
    tick();
  endtask

  // Three-pulse MCS-80 sequence with level 5 request; second byte given by caller.
  task automatic run_mcs80(input string tag, input logic [7:0] byte2);
    ack_if.interrupt = 8'h20;
    tick();
    check({tag, ".req"}, 32'(ack_if.interrupt_to_cpu), 32'd1);
    inta(1'b0);
    check_all({tag, ".p1"}, 1'b0, 8'h20, 1'b0, 1'b1, 8'hCD);
    ack_if.interrupt = 8'h00;
    inta(1'b1);
    check_all({tag, ".g1"}, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    inta(1'b0);
    check_all({tag, ".p2"}, 1'b0, 8'h00, 1'b0, 1'b1, byte2);
    inta(1'b1);
    check_all({tag, ".g2"}, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    inta(1'b0);
    check_all({tag, ".p3"}, 1'b0, 8'h00, 1'b0, 1'b1, 8'h12);
    inta(1'b1);
    check_all({tag, ".end"}, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    tick();
    check({tag, ".eoa1"}, 32'(ack_if.end_of_acknowledge_sequence), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    icw1 = 1'b0;
    mode_8086 = 1'b1;
    interval_4 = 1'b1;
    val = 3'b000;
    vah = 8'h40;
    ack_if.interrupt = 8'h00;
    ack_if.interrupt_acknowledge_n = 1'b1;
    tick();
    tick();
    check_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    reset_n = 1'b1;
    tick();

    // 8086, level 3, vector base 0x40.
    ack_if.interrupt = 8'h08;
    tick();
    check("t1.req", 32'(ack_if.interrupt_to_cpu), 32'd1);
    inta(1'b0);
    check_all("t1.p1", 1'b0, 8'h08, 1'b0, 1'b0, 8'h00);
    ack_if.interrupt = 8'h00;
    tick();
    check("t1.ack1", 32'(ack_if.acknowledge_interrupt), 32'h00);
    inta(1'b1);
    check_all("t1.g1", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    inta(1'b0);
    check_all("t1.p2", 1'b0, 8'h00, 1'b0, 1'b1, 8'h43);
    tick();
    check("t1.p2hold", 32'(ack_if.control_logic_data), 32'h43);
    inta(1'b1);
    check_all("t1.end", 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    tick();
    check("t1.eoa1", 32'(ack_if.end_of_acknowledge_sequence), 32'd0);

    // MCS-80, A7..A5=101, ICW2=0x12.
    mode_8086 = 1'b0;
    val = 3'b101;
    vah = 8'h12;
    interval_4 = 1'b1;
    run_mcs80("t2", 8'hB4);
    interval_4 = 1'b0;
    run_mcs80("t3", 8'hA8);

    // Spurious: request withdrawn as INTA# falls.
    mode_8086 = 1'b1;
    vah = 8'h40;
    ack_if.interrupt = 8'h01;
    tick();
    check("t4.req", 32'(ack_if.interrupt_to_cpu), 32'd1);
    ack_if.interrupt = 8'h00;
    inta(1'b0);
    check_all("t4.p1", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    inta(1'b1);
    inta(1'b0);
    check_all("t4.p2", 1'b0, 8'h00, 1'b0, 1'b1, 8'h47);
    inta(1'b1);
    check_all("t4.end", 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // Timeout: 8 stalled cycles in G1 abandon the sequence.
    ack_if.interrupt = 8'h04;
    tick();
    inta(1'b0);
    check("t5.ack", 32'(ack_if.acknowledge_interrupt), 32'h04);
    inta(1'b1);
    for (int i = 0; i < 6; i++) tick();
    check("t5.inthold", 32'(ack_if.interrupt_to_cpu), 32'd0);
    tick();
    tick();
    check("t5.noeoa", 32'(ack_if.end_of_acknowledge_sequence), 32'd0);
    tick();
    check("t5.reint", 32'(ack_if.interrupt_to_cpu), 32'd1);
    check("t5.noeoa2", 32'(ack_if.end_of_acknowledge_sequence), 32'd0);
    inta(1'b0);
    check_all("t5.fresh", 1'b0, 8'h04, 1'b0, 1'b0, 8'h00);
    ack_if.interrupt = 8'h00;
    inta(1'b1);
    inta(1'b0);
    check("t5.p2", 32'(ack_if.control_logic_data), 32'h42);
    inta(1'b1);
    check("t5.end", 32'(ack_if.end_of_acknowledge_sequence), 32'd1);

    // ICW1 abort coincident with rise 2.
    ack_if.interrupt = 8'h02;
    tick();
    inta(1'b0);
    ack_if.interrupt = 8'h00;
    inta(1'b1);
    inta(1'b0);
    check_all("t6.p2", 1'b0, 8'h00, 1'b0, 1'b1, 8'h41);
    icw1 = 1'b1;
    inta(1'b1);
    icw1 = 1'b0;
    check_all("t6.abort", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
    check("t6.noeoa", 32'(ack_if.end_of_acknowledge_sequence), 32'd0);

    // Reset asserted in P2.
    ack_if.interrupt = 8'h80;
    tick();
    inta(1'b0);
    ack_if.interrupt = 8'h00;
    inta(1'b1);
    inta(1'b0);
    check_all("t7.p2", 1'b0, 8'h00, 1'b0, 1'b1, 8'h47);
    reset_n = 1'b0;
    inta(1'b1);
    check_all("t7.reset", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    reset_n = 1'b1;
    tick();
    check("t7.noeoa", 32'(ack_if.end_of_acknowledge_sequence), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
